// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for a 32-point radix-2 FFT: tracks the current stage and issues registered
// butterfly operand addresses and twiddle indices. It also forwards butterfly completions to the iteration counter.
module fft_stage_ctrl (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       start,
    input  logic       bfly_done,
    input  logic       stage_strobe,
    input  logic [4:0] bfly_idx,
    output logic       iteration_strobe,
    output logic [2:0] stage_count,
    output logic [4:0] addr_a,
    output logic [4:0] addr_b,
    output logic [3:0] twiddle_idx,
    output logic       addr_valid,
    output logic       busy,
    output logic       fft_done
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] LAST_STAGE = 3'd4;

    state_t     state_reg, state_next;
    logic [2:0] stage_reg, stage_next;
    logic [4:0] addr_a_reg, addr_b_reg;
    logic [3:0] twiddle_reg;
    logic       addr_valid_reg;
    logic       iter_reg;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (stage_strobe && stage_reg == LAST_STAGE) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg == RUN);
        fft_done = (state_reg == DONE);
    end

    // The stage counter saturates at the last stage; leaving RUN is decided by the FSM.
    always_comb begin
        stage_next = stage_reg;
        if (state_reg == IDLE) begin
            stage_next = 3'd0;
        end else if (state_reg == RUN && stage_strobe && stage_reg != LAST_STAGE) begin
            stage_next = stage_reg + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stage_reg <= 3'd0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    // One constant-shift address generator per stage; the live stage selects among them.
    logic [4:0] k5;
    logic [4:0] cand_pos [5];
    logic [4:0] cand_a   [5];
    logic [4:0] cand_b   [5];
    logic [3:0] cand_tw  [5];

    assign k5 = {1'b0, bfly_idx[3:0]};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_stage_addr
            localparam logic [4:0] HALF      = 5'(1 << gi);
            localparam logic [4:0] HALF_MASK = 5'((1 << gi) - 1);
            assign cand_pos[gi] = k5 & HALF_MASK;
            assign cand_a[gi]   = ((k5 >> gi) << (gi + 1)) + cand_pos[gi];
            assign cand_b[gi]   = cand_a[gi] + HALF;
            assign cand_tw[gi]  = 4'(cand_pos[gi] << (4 - gi));
        end
    endgenerate

    logic [4:0] sel_a, sel_b;
    logic [3:0] sel_tw;

    always_comb begin
        sel_a  = cand_a[4];
        sel_b  = cand_b[4];
        sel_tw = cand_tw[4];
        case (stage_reg)
            3'd0: begin sel_a = cand_a[0]; sel_b = cand_b[0]; sel_tw = cand_tw[0]; end
            3'd1: begin sel_a = cand_a[1]; sel_b = cand_b[1]; sel_tw = cand_tw[1]; end
            3'd2: begin sel_a = cand_a[2]; sel_b = cand_b[2]; sel_tw = cand_tw[2]; end
            3'd3: begin sel_a = cand_a[3]; sel_b = cand_b[3]; sel_tw = cand_tw[3]; end
            default: ;
        endcase
    end

    logic idx_ok;
    assign idx_ok = (state_reg == RUN) && !bfly_idx[4];

    // Addresses only reload on a valid index so an out-of-range index leaves them stable.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            addr_a_reg     <= 5'd0;
            addr_b_reg     <= 5'd0;
            twiddle_reg    <= 4'd0;
            addr_valid_reg <= 1'b0;
            iter_reg       <= 1'b0;
        end else begin
            addr_valid_reg <= idx_ok;
            iter_reg       <= bfly_done && (state_reg == RUN);
            if (idx_ok) begin
                addr_a_reg  <= sel_a;
                addr_b_reg  <= sel_b;
                twiddle_reg <= sel_tw;
            end
        end
    end

    assign iteration_strobe = iter_reg;
    assign stage_count      = stage_reg;
    assign addr_a           = addr_a_reg;
    assign addr_b           = addr_b_reg;
    assign twiddle_idx      = twiddle_reg;
    assign addr_valid       = addr_valid_reg;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: an arithmetic reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fft_stage_ctrl;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic       start = 1'b0;
    logic       bfly_done = 1'b0;
    logic       stage_strobe = 1'b0;
    logic [4:0] bfly_idx = 5'd0;
    logic       iteration_strobe;
    logic [2:0] stage_count;
    logic [4:0] addr_a;
    logic [4:0] addr_b;
    logic [3:0] twiddle_idx;
    logic       addr_valid;
    logic       busy;
    logic       fft_done;

    fft_stage_ctrl dut (
        .clk              (clk),
        .n_reset          (n_reset),
        .start            (start),
        .bfly_done        (bfly_done),
        .stage_strobe     (stage_strobe),
        .bfly_idx         (bfly_idx),
        .iteration_strobe (iteration_strobe),
        .stage_count      (stage_count),
        .addr_a           (addr_a),
        .addr_b           (addr_b),
        .twiddle_idx      (twiddle_idx),
        .addr_valid       (addr_valid),
        .busy             (busy),
        .fft_done         (fft_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: mode 0=idle, 1=run, 2=done; addresses from divide/modulo arithmetic.
    int m_state = 0, m_stage = 0, m_a = 0, m_b = 0, m_tw = 0, m_valid = 0, m_iter = 0;

    always @(posedge clk or negedge n_reset) begin : model
        int k, h, pos;
        if (!n_reset) begin
            m_state = 0; m_stage = 0; m_a = 0; m_b = 0; m_tw = 0; m_valid = 0; m_iter = 0;
        end else begin
            k = int'(bfly_idx);
            m_iter = (bfly_done && m_state == 1) ? 1 : 0;
            if (m_state == 1 && k < 16) begin
                h       = 1 << m_stage;
                pos     = k % h;
                m_a     = (k / h) * 2 * h + pos;
                m_b     = m_a + h;
                m_tw    = pos * (16 / h);
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
            case (m_state)
                0: begin m_stage = 0; if (start) m_state = 1; end
                1: if (stage_strobe) begin
                       if (m_stage < 4) m_stage = m_stage + 1;
                       else m_state = 2;
                   end
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy",             int'(busy),             (m_state == 1) ? 1 : 0);
            chk("fft_done",         int'(fft_done),         (m_state == 2) ? 1 : 0);
            chk("stage_count",      int'(stage_count),      m_stage);
            chk("iteration_strobe", int'(iteration_strobe), m_iter);
            chk("addr_valid",       int'(addr_valid),       m_valid);
            chk("addr_a",           int'(addr_a),           m_a);
            chk("addr_b",           int'(addr_b),           m_b);
            chk("twiddle_idx",      int'(twiddle_idx),      m_tw);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   int'(busy), 0);
        chk({tag, "_done"},   int'(fft_done), 0);
        chk({tag, "_stage"},  int'(stage_count), 0);
        chk({tag, "_iter"},   int'(iteration_strobe), 0);
        chk({tag, "_valid"},  int'(addr_valid), 0);
        chk({tag, "_addr_a"}, int'(addr_a), 0);
        chk({tag, "_addr_b"}, int'(addr_b), 0);
        chk({tag, "_tw"},     int'(twiddle_idx), 0);
    endtask

    initial begin
        #2 n_reset = 1'b0;
        check_en = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        n_reset = 1'b1;

        // Idle: strobes and completions must not disturb anything
        for (int i = 0; i < 10; i++) begin
            stage_strobe = (i == 3);
            bfly_done    = (i == 5 || i == 6);
            tick();
            chk("idle_busy", int'(busy), 0);
        end
        stage_strobe = 1'b0;
        bfly_done    = 1'b0;
        tick();
        chk("idle_stage", int'(stage_count), 0);
        chk("idle_iter", int'(iteration_strobe), 0);

        // Address sweep over every stage and index
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < 16; k++) begin
                bfly_idx = 5'(k);
                tick();
                if (s == 0 && k == 5) begin
                    chk("s0k5_a", int'(addr_a), 10);
                    chk("s0k5_b", int'(addr_b), 11);
                    chk("s0k5_tw", int'(twiddle_idx), 0);
                end
                if (s == 2 && k == 5) begin
                    chk("s2k5_a", int'(addr_a), 9);
                    chk("s2k5_b", int'(addr_b), 13);
                    chk("s2k5_tw", int'(twiddle_idx), 4);
                end
                if (s == 4 && k == 15) begin
                    chk("s4k15_a", int'(addr_a), 15);
                    chk("s4k15_b", int'(addr_b), 31);
                    chk("s4k15_tw", int'(twiddle_idx), 15);
                end
            end
            if (s < 4) begin
                stage_strobe = 1'b1;
                tick();
                stage_strobe = 1'b0;
            end
        end

        // Out-of-range index holds the previous address
        bfly_idx = 5'd16;
        tick();
        chk("oor_valid", int'(addr_valid), 0);
        chk("oor_hold_a", int'(addr_a), 15);

        // Strobe forwarding in RUN
        bfly_done = 1'b1;
        tick();
        bfly_done = 1'b0;
        chk("fwd_iter", int'(iteration_strobe), 1);
        tick();
        chk("fwd_iter_low", int'(iteration_strobe), 0);
        bfly_idx = 5'd0;

        // Final strobe, then start during DONE
        stage_strobe = 1'b1;
        tick();
        stage_strobe = 1'b0;
        chk("done_pulse", int'(fft_done), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_stage", int'(stage_count), 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_once", int'(fft_done), 0);
        chk("done_start_ign", int'(busy), 0);
        tick();
        chk("after_done_busy", int'(busy), 0);
        chk("after_done_stage", int'(stage_count), 0);

        // Full transform with spaced strobes, start at stage 2, combined strobe+done at stage 1
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 5; p++) begin
            repeat (19) tick();
            chk("ft_stage", int'(stage_count), p);
            if (p == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("ft_restart_stage", int'(stage_count), 2);
                chk("ft_restart_busy", int'(busy), 1);
            end
            stage_strobe = 1'b1;
            bfly_done    = (p == 1);
            tick();
            stage_strobe = 1'b0;
            bfly_done    = 1'b0;
            if (p < 4) chk("ft_step", int'(stage_count), p + 1);
            if (p == 1) chk("ft_both_iter", int'(iteration_strobe), 1);
            if (p == 4) begin
                chk("ft_done", int'(fft_done), 1);
                chk("ft_busy_fall", int'(busy), 0);
            end
        end
        tick();
        chk("ft_done_once", int'(fft_done), 0);

        // Asynchronous reset in the middle of stage 3
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        bfly_idx = 5'd7;
        for (int p = 0; p < 3; p++) begin
            tick();
            stage_strobe = 1'b1;
            tick();
            stage_strobe = 1'b0;
        end
        tick();
        chk("mid_stage3", int'(stage_count), 3);
        chk("mid_valid", int'(addr_valid), 1);
        n_reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        n_reset = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_no_done", int'(fft_done), 0);
            chk("rst_idle", int'(busy), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
